// File: rtl/rubik_pkg.sv
// Shared types for the 2x2 cube scrambler: command encoding, faces, turns, FSM states, LFSR constants.
package rubik_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_U   = 4'd1;
  localparam cmd_t CMD_UP  = 4'd2;
  localparam cmd_t CMD_U2  = 4'd3;
  localparam cmd_t CMD_F   = 4'd4;
  localparam cmd_t CMD_FP  = 4'd5;
  localparam cmd_t CMD_F2  = 4'd6;
  localparam cmd_t CMD_R   = 4'd7;
  localparam cmd_t CMD_RP  = 4'd8;
  localparam cmd_t CMD_R2  = 4'd9;

  typedef enum logic [1:0] {FACE_U = 2'd0, FACE_F = 2'd1, FACE_R = 2'd2} face_t;
  typedef enum logic [1:0] {TURN_CW = 2'd0, TURN_CCW = 2'd1, TURN_HALF = 2'd2} turn_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SCRAMBLE, ST_UNDO} state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // Quarter turns swap direction; half turns and reserved codes map to themselves / NOP.
  function automatic cmd_t cmd_inverse(input cmd_t c);
    cmd_t r;
    case (c)
      CMD_U:   r = CMD_UP;
      CMD_UP:  r = CMD_U;
      CMD_F:   r = CMD_FP;
      CMD_FP:  r = CMD_F;
      CMD_R:   r = CMD_RP;
      CMD_RP:  r = CMD_R;
      CMD_U2, CMD_F2, CMD_R2: r = c;
      default: r = CMD_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rubik_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400, right shift) with seed load and advance enable.
module rubik_lfsr16
  import rubik_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] r_state;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // A load that coincides with an issued move steps past the seed in the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= LFSR_DEFAULT;
    end else if (load_i) begin
      r_state <= adv_i ? lfsr_step(seed_i) : seed_i;
    end else if (adv_i) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/rubik_scrambler.sv
// Pseudo-random scramble command source for the 2x2 cube engine.
// Define RUBIK_SCRAMBLE_UNDO_EN to replay the inverse sequence after the scramble.
module rubik_scrambler
  import rubik_pkg::*;
#(
  parameter  int MAX_LEN = 64,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [15:0]      seed_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             pause_i,
  output logic [3:0]       cmd_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] count_o
);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  face_t            r_prev_face;
  cmd_t             r_cmd;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_issue;
  logic [LEN_W-1:0] w_len;
  logic [15:0]      w_seed;
  logic [15:0]      w_lfsr;
  logic [15:0]      w_cur;
  face_t            w_face;
  cmd_t             w_move;

  function automatic face_t move_face(input face_t prev, input logic [15:0] l);
    logic [2:0] s;
    s = {1'b0, prev} + 3'd1 + {2'b00, l[0]};
    if (s >= 3'd3) s = s - 3'd3;
    return face_t'(s[1:0]);
  endfunction

  function automatic cmd_t move_cmd(input face_t f, input logic [15:0] l);
    logic [1:0] t;
    t = (l[2:1] == 2'd3) ? 2'd2 : l[2:1];
    return 4'd1 + 4'd3 * {2'b00, f} + {2'b00, t};
  endfunction

  assign w_accept = (r_state == ST_IDLE) && start_i;
  assign w_len    = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
  assign w_seed   = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
  assign w_issue  = (w_accept && (w_len != '0)) ||
                    ((r_state == ST_SCRAMBLE) && !pause_i && (r_count != r_len));
  // The move presented right after an accepted start is drawn from the seed itself.
  assign w_cur    = w_accept ? w_seed : w_lfsr;
  assign w_face   = move_face(w_accept ? FACE_R : r_prev_face, w_cur);
  assign w_move   = move_cmd(w_face, w_cur);

  rubik_lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_accept),
    .adv_i   (w_issue),
    .seed_i  (w_seed),
    .state_o (w_lfsr)
  );

`ifdef RUBIK_SCRAMBLE_UNDO_EN
  localparam int HIST_AW = $clog2(MAX_LEN);

  cmd_t r_hist [MAX_LEN];
  cmd_t w_pop;

  assign w_pop = cmd_inverse(r_hist[HIST_AW'(r_count - LEN_W'(1))]);

  always_ff @(posedge clk_i) begin
    if (w_issue) r_hist[w_accept ? '0 : HIST_AW'(r_count)] <= w_move;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_prev_face <= FACE_R;
      r_cmd       <= CMD_NOP;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd <= CMD_NOP;
          if (start_i) begin
            r_len       <= w_len;
            r_count     <= '0;
            r_prev_face <= FACE_R;
            if (w_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_SCRAMBLE;
              r_busy      <= 1'b1;
              r_cmd       <= w_move;
              r_count     <= LEN_W'(1);
              r_prev_face <= w_face;
            end
          end
        end
        ST_SCRAMBLE: begin
          if (pause_i) begin
            r_cmd <= CMD_NOP;
          end else if (r_count != r_len) begin
            r_cmd       <= w_move;
            r_count     <= r_count + LEN_W'(1);
            r_prev_face <= w_face;
          end else begin
`ifdef RUBIK_SCRAMBLE_UNDO_EN
            r_state <= ST_UNDO;
            r_cmd   <= w_pop;
            r_count <= r_count - LEN_W'(1);
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cmd   <= CMD_NOP;
`endif
          end
        end
`ifdef RUBIK_SCRAMBLE_UNDO_EN
        ST_UNDO: begin
          if (pause_i) begin
            r_cmd <= CMD_NOP;
          end else if (r_count != '0) begin
            r_cmd   <= w_pop;
            r_count <= r_count - LEN_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cmd   <= CMD_NOP;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cmd   <= CMD_NOP;
        end
      endcase
    end
  end

  assign cmd_o   = r_cmd;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign count_o = r_count;

endmodule
